fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Read-side consumer for the 8-deep byte FIFO. It pops bytes from the FIFO read port and serializes each one as an 8N1 UART frame on `tx`. It sits directly on the FIFO's `rd_en`/`buf_out`/`buf_empty` pins and drains the buffer that upstream logic fills through `wr_en`/`buf_in`.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be ≥ 2.
- `DATA_W`, 8: byte width; must match the FIFO data width.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  allows new frames to start; a frame already in flight always completes.
- `buf_out`  in  DATA_W  FIFO read data, valid the cycle after a `rd_en` pop.
- `buf_empty`  in  1  FIFO empty flag.
- `rd_en`  out  1  FIFO pop strobe, one-cycle pulse per byte.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high from the pop through the end of the stop bit.
- `tx_done`  out  1  one-cycle pulse on the last cycle of each stop bit.
- `frame_count`  out  16  frames completed since reset; wraps 0xFFFF→0x0000.

## Operation
- FSM states: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE → POP when `enable && !buf_empty`. Otherwise stay in IDLE.
- POP: `rd_en`=1 for exactly this cycle → LOAD.
- LOAD: capture `buf_out` into the shift register, clear the baud counter → START.
- START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
- DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each. A 3-bit index advances on each baud tick. After bit 7 → STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last cycle, pulse `tx_done` and increment `frame_count`. Then:
  - → POP if `enable && !buf_empty` (back-to-back frames, no idle gap);
  - → IDLE otherwise.
- `rd_en` is never asserted while `buf_empty`=1.
- `rd_en` is never asserted outside POP, so at most one pop occurs per frame.
- Deasserting `enable` mid-frame has no effect until STOP ends.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, and the tick fires at CLKS_PER_BIT-1.
- `busy` = (state != IDLE).

## Timing
- Reset values (async, on `rst`=0):
  - state=IDLE, `tx`=1, `rd_en`=0, `busy`=0, `tx_done`=0, `frame_count`=0;
  - shift register, bit index and baud counter all 0.
- All outputs are registered.
- Pop-to-start latency: `rd_en` high in cycle N, `buf_out` sampled at edge N+1, `tx` falls in cycle N+2.
- Frame length: 10·CLKS_PER_BIT cycles from the falling edge of `tx` to the end of the stop bit.
- Back-to-back frame period: 10·CLKS_PER_BIT + 2 cycles (POP and LOAD both hold `tx`=1).
- `buf_empty` is sampled only in IDLE and on the last STOP cycle. A FIFO write arriving mid-frame is picked up at the end of the frame.
- Reset asserted mid-frame:
  - `tx` returns to 1 immediately, which truncates the frame;
  - no `tx_done` pulse, `frame_count` cleared;
  - a byte already popped is lost.
- Simultaneous upstream FIFO write and this block's pop are legal. FIFO counter behaviour is the FIFO's concern.

## Structure
- Shared header `fifo_uart_defs.vh`: state encodings (3-bit localparams IDLE=0 … STOP=5) and the default CLKS_PER_BIT.
- One sub-module, `baud_tick_gen`:
  - inputs: `clk`, `rst`, `clear`;
  - output: `tick`;
  - holds the CLKS_PER_BIT counter, reused for START, DATA and STOP.
- The FSM, shift register, bit index and `frame_count` live in `fifo_uart_tx`.

## Test plan
All scenarios use CLKS_PER_BIT=4 with the real FIFO instantiated in front of the block.
- **Reset idle:** hold `rst`=0 for 3 cycles, then release with FIFO empty and `enable`=1 → `tx`=1, `rd_en`=0, `busy`=0, `frame_count`=0 for 20 cycles.
- **Single byte:** write 0xA5, `enable`=1 → exactly one `rd_en` pulse; `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; `tx_done` pulses once; `frame_count`=1; `buf_empty`=1 afterwards.
- **Back-to-back:** fill the FIFO with 8 bytes 0x01…0x08 → 8 frames in order, each 42 cycles apart; `frame_count`=8; `buf_full` drops after the first pop.
- **Enable gating:** write 0x3C with `enable`=0 → no `rd_en` for 50 cycles. Raise `enable` → frame for 0x3C. Drop `enable` mid-DATA → the frame still completes.
- **Reset mid-frame:** assert `rst` during DATA bit 3 of 0xFF → `tx`=1 within the same cycle, `busy`=0, `frame_count`=0. After release, no spurious frame with the FIFO empty.
- **Late write:** write 0x11, then write 0x22 during START of the first frame → 0x22 is sent immediately after 0x11's stop bit, with no idle gap.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// Holds the FSM state encoding and the default bit period.
package fifo_uart_tx_pkg;

  localparam int unsigned DefaultClksPerBit = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPop   = 3'd1,
    StLoad  = 3'd2,
    StStart = 3'd3,
    StData  = 3'd4,
    StStop  = 3'd5
  } state_e;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period counter shared by the START, DATA and STOP phases.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   clear    : hold the counter at zero
//   tick     : high on the last cycle of each bit period (count == CLKS_PER_BIT-1)
//   tick_pre : high one cycle before tick (count == CLKS_PER_BIT-2)
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic tick_pre
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick     = (cnt_q == CntW'(CLKS_PER_BIT - 1));
  // Lets the parent raise a registered strobe that lines up with tick.
  assign tick_pre = (cnt_q == CntW'(CLKS_PER_BIT - 2));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and sends each byte as an 8N1 UART frame.
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset
//   enable      : permits new frames; a frame in flight always completes
//   buf_out     : FIFO read data, valid the cycle after rd_en
//   buf_empty   : FIFO empty flag
//   rd_en       : one-cycle FIFO pop strobe per byte
//   tx          : serial line, idle high
//   busy        : high from the pop through the end of the stop bit
//   tx_done     : one-cycle pulse on the last cycle of the stop bit
//   frame_count : frames completed since reset, wrapping
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] buf_out,
  input  logic              buf_empty,
  output logic              rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic [15:0]       frame_count
);

  localparam int unsigned IdxW = $clog2(DATA_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [15:0]       count_q, count_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, busy_q, tx_done_q, tx_done_d;
  logic              tick, tick_pre, baud_clear;

  // Counter runs only while a bit is on the line; LOAD leaves it at zero for START.
  assign baud_clear = !(state_q inside {StStart, StData, StStop});

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear),
    .tick    (tick),
    .tick_pre(tick_pre)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    count_d   = count_q;
    tx_done_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable && !buf_empty) begin
          state_d = StPop;
        end
      end
      StPop: state_d = StLoad;
      StLoad: begin
        shift_d = buf_out;
        idx_d   = '0;
        state_d = StStart;
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          if (idx_q == IdxW'(DATA_W - 1)) begin
            state_d = StStop;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      StStop: begin
        // Registered strobe/count land on the final stop cycle.
        if (tick_pre) begin
          tx_done_d = 1'b1;
          count_d   = count_q + 16'd1;
        end
        if (tick) begin
          state_d = (enable && !buf_empty) ? StPop : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is decoded from the next state so tx stays a flop output.
    tx_d = 1'b1;
    if (state_d == StStart) begin
      tx_d = 1'b0;
    end else if (state_d == StData) begin
      tx_d = shift_d[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      tx_q      <= tx_d;
      rd_en_q   <= (state_d == StPop);
      busy_q    <= (state_d != StIdle);
      tx_done_q <= tx_done_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign tx_done     = tx_done_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with a behavioural 8-deep FIFO in front of it.
// Written bytes go into a scoreboard queue; a line monitor decodes frames
// from tx and compares them against the queue.
module tb_fifo_uart_tx;

  localparam int unsigned Cpb         = 4;
  localparam int unsigned FrameCycles = 10 * Cpb;
  localparam int unsigned Period      = FrameCycles + 2;
  localparam int unsigned FifoDepth   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  buf_in = 8'h00;
  logic [7:0]  buf_out = 8'h00;
  logic        buf_empty = 1'b1;
  logic        rd_en, tx, busy, tx_done;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(Cpb),
    .DATA_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .buf_out    (buf_out),
    .buf_empty  (buf_empty),
    .rd_en      (rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .frame_count(frame_count)
  );

  // Behavioural FIFO: registered read data, registered empty flag.
  logic [7:0] fifo_mem[$];
  always @(posedge clk) begin
    if (rd_en && fifo_mem.size() > 0) buf_out <= fifo_mem.pop_front();
    if (wr_en && fifo_mem.size() < FifoDepth) fifo_mem.push_back(buf_in);
    buf_empty <= (fifo_mem.size() == 0);
  end

  int n_checks = 0;
  int n_pass = 0;
  int cycle = 0;
  always @(posedge clk) cycle++;

  logic [7:0] exp_q[$];
  int start_times[$];
  int exp_frames = 0;
  int frames_seen = 0;
  int rd_cnt = 0;
  int td_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Line monitor: decode each frame at mid-bit, independent of DUT internals.
  initial begin : monitor
    logic       prev_tx;
    logic [7:0] data;
    logic       ok, td_ok;
    bit         aborted;
    int         k;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_tx = 1'b1;
      end else if (prev_tx && !tx) begin
        start_times.push_back(cycle);
        data = '0; ok = 1'b1; td_ok = 1'b0; aborted = 0;
        for (int c = 1; c < FrameCycles && !aborted; c++) begin
          @(negedge clk);
          if (!rst) begin
            aborted = 1;
          end else begin
            if (c % Cpb == Cpb / 2) begin
              k = c / Cpb;
              if (k == 0) ok &= (tx == 1'b0);
              else if (k <= 8) data[k-1] = tx;
              else ok &= (tx == 1'b1);
            end
            if (c == FrameCycles - 1) td_ok = tx_done;
          end
        end
        if (!aborted) begin
          frames_seen++;
          check("frame framing", ok, 1);
          check("tx_done on last stop cycle", td_ok, 1);
          if (exp_q.size() == 0) check("unexpected frame data", data, 64'h100);
          else check("frame data", data, exp_q.pop_front());
          prev_tx = tx;
        end else begin
          prev_tx = 1'b1;
        end
      end else begin
        prev_tx = tx;
      end
    end
  end

  // Pop-strobe and done-strobe bookkeeping.
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (tx_done) td_cnt++;
      if (rd_en) begin
        rd_cnt++;
        check("rd_en while empty", buf_empty, 0);
        check("rd_en single cycle", prev_rd, 0);
      end
      prev_rd = rd_en;
    end else begin
      prev_rd = 1'b0;
    end
  end

  task automatic write_byte(input logic [7:0] b);
    for (int i = 0; i < 5000 && fifo_mem.size() >= FifoDepth; i++) @(negedge clk);
    @(negedge clk);
    wr_en = 1'b1;
    buf_in = b;
    exp_q.push_back(b);
    exp_frames++;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo_mem.size() == 0 && !busy && !wr_en) done = 1;
    end
    check("drain completed", done, 1);
  endtask

  task automatic wait_start();
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (tx == 1'b0) seen = 1;
    end
    check("frame start seen", seen, 1);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r0, t0, s0;
    logic [7:0] b;

    // Reset idle
    @(negedge clk);
    check("in reset", {tx, rd_en, busy, tx_done, frame_count}, {4'b1000, 16'h0});
    repeat (2) @(negedge clk);
    enable = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset idle", {tx, rd_en, busy, frame_count}, {3'b100, 16'h0});
    end

    // Single byte
    r0 = rd_cnt; t0 = td_cnt;
    write_byte(8'hA5);
    drain(200);
    check("single rd_en pulses", rd_cnt - r0, 1);
    check("single tx_done pulses", td_cnt - t0, 1);
    check("single frame_count", frame_count, exp_frames);
    check("single buf_empty after", buf_empty, 1);

    // Back-to-back
    s0 = start_times.size();
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    drain(800);
    check("b2b frame_count", frame_count, exp_frames);
    check("b2b frames started", start_times.size() - s0, 8);
    for (int i = s0 + 1; i < s0 + 8 && i < start_times.size(); i++)
      check("b2b spacing", start_times[i] - start_times[i-1], Period);

    // Enable gating
    enable = 1'b0;
    r0 = rd_cnt;
    write_byte(8'h3C);
    repeat (50) @(negedge clk);
    check("gated no pop", rd_cnt - r0, 0);
    check("gated not busy", busy, 0);
    enable = 1'b1;
    wait_start();
    repeat (10) @(negedge clk);
    enable = 1'b0;
    drain(200);
    check("gated frame_count", frame_count, exp_frames);
    enable = 1'b1;

    // Reset mid-frame during data bit 3
    write_byte(8'hFF);
    wait_start();
    repeat (16) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid reset tx", tx, 1);
    check("mid reset busy", busy, 0);
    check("mid reset frame_count", frame_count, 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    exp_frames = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    r0 = rd_cnt; s0 = start_times.size();
    repeat (30) @(negedge clk);
    check("post reset no pop", rd_cnt - r0, 0);
    check("post reset no frame", start_times.size() - s0, 0);
    check("post reset idle", {tx, busy, frame_count}, {2'b10, 16'h0});

    // Late write during START of the first frame
    s0 = start_times.size();
    write_byte(8'h11);
    wait_start();
    write_byte(8'h22);
    drain(300);
    check("late frames started", start_times.size() - s0, 2);
    if (start_times.size() >= s0 + 2)
      check("late spacing", start_times[s0+1] - start_times[s0], Period);
    check("late frame_count", frame_count, exp_frames);

    // Randomized traffic with enable toggling
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 4) == 0) enable = ~enable;
      if (fifo_mem.size() >= FifoDepth - 1) enable = 1'b1;
      write_byte(b);
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    enable = 1'b1;
    drain(20000);
    check("random frame_count", frame_count, exp_frames);
    check("tx_done per frame", td_cnt, frames_seen);
    check("one pop per frame", rd_cnt, frames_seen + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
